// File: rtl/dla_seq_pkg.sv
// Shared types, constants and descriptor helpers for the DLA layer sequencer.
package dla_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        WAIT_DONE,
        CLR,
        WAIT_IDLE,
        FINISH
    } seq_state_t;

    localparam logic [1:0] WSEL_MAPPING    = 2'd0;
    localparam logic [1:0] WSEL_SHAPE1     = 2'd1;
    localparam logic [1:0] WSEL_SHAPE2     = 2'd2;
    localparam logic [1:0] WSEL_OPCFG      = 2'd3;
    localparam int         DESC_BYTES      = 16;
    localparam int         OPCFG_START_BIT = 0;

    // Byte address of word k of a layer descriptor; wraps modulo 2^32.
    function automatic logic [31:0] desc_word_addr(input logic [31:0] base,
                                                   input logic [31:0] layer,
                                                   input logic [1:0]  word);
        return base + (layer * 32'(DESC_BYTES)) + {28'd0, word, 2'b00};
    endfunction

    function automatic logic [1:0] next_word(input logic [1:0] word);
        case (word)
            WSEL_MAPPING: return WSEL_SHAPE1;
            WSEL_SHAPE1:  return WSEL_SHAPE2;
            default:      return WSEL_OPCFG;
        endcase
    endfunction

endpackage

// File: rtl/dla_seq_watchdog.sv
// Cycle counter that flags expiry once it has been enabled for TIMEOUT_CYCLES cycles.
module dla_seq_watchdog #(
    parameter int                      TIMEOUT_BITS   = 24,
    parameter logic [TIMEOUT_BITS-1:0] TIMEOUT_CYCLES = 24'hFF_FFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_BITS-1:0] LAST_COUNT = TIMEOUT_CYCLES - 1'b1;

    logic [TIMEOUT_BITS-1:0] count_reg;

    // Expiry is reported during the final enabled cycle so the caller reacts on that edge.
    assign expired = enable && (count_reg == LAST_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != LAST_COUNT)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/dla_layer_sequencer.sv
// Walks per-layer descriptors and programs the DLA control registers layer by layer.
module dla_layer_sequencer
    import dla_seq_pkg::*;
#(
    parameter int                      MAX_LAYERS_BITS = 8,
    parameter int                      TIMEOUT_BITS    = 24,
    parameter logic [TIMEOUT_BITS-1:0] TIMEOUT_CYCLES  = 24'hFF_FFFF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [31:0]                desc_base,
    input  logic [MAX_LAYERS_BITS-1:0] num_layers,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [MAX_LAYERS_BITS-1:0] layer_idx,
    output logic                       mem_re,
    output logic [31:0]                mem_addr,
    input  logic [31:0]                mem_rdata,
    output logic                       ctrl_reg_w_en,
    output logic [1:0]                 ctrl_reg_wsel,
    output logic [31:0]                ctrl_reg_wdata,
    input  logic                       dla_done
);

    localparam logic [31:0] START_MASK = 32'd1 << OPCFG_START_BIT;

    seq_state_t                 state_reg;
    logic [31:0]                base_reg;
    logic [MAX_LAYERS_BITS-1:0] nlayers_reg;
    logic [1:0]                 word_reg;
    logic [31:0]                op_cfg_q;
    logic                       wd_clear;
    logic                       wd_enable;
    logic                       wd_expired;

    assign wd_clear  = (state_reg == WR) && (word_reg == WSEL_OPCFG);
    assign wd_enable = (state_reg == WAIT_DONE);

    dla_seq_watchdog #(
        .TIMEOUT_BITS   (TIMEOUT_BITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Write data comes straight from memory in WR so the descriptor needs no staging register.
    always_comb begin
        ctrl_reg_wdata = '0;
        if (state_reg == WR) begin
            ctrl_reg_wdata = (word_reg == WSEL_OPCFG) ? (mem_rdata | START_MASK) : mem_rdata;
        end else if (state_reg == CLR) begin
            ctrl_reg_wdata = op_cfg_q & ~START_MASK;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            nlayers_reg   <= '0;
            word_reg      <= WSEL_MAPPING;
            op_cfg_q      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            layer_idx     <= '0;
            mem_re        <= 1'b0;
            mem_addr      <= '0;
            ctrl_reg_w_en <= 1'b0;
            ctrl_reg_wsel <= WSEL_MAPPING;
        end else begin
            mem_re        <= 1'b0;
            ctrl_reg_w_en <= 1'b0;
            done          <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        base_reg    <= desc_base;
                        nlayers_reg <= num_layers;
                        err         <= 1'b0;
                        layer_idx   <= '0;
                        word_reg    <= WSEL_MAPPING;
                        busy        <= 1'b1;
                        if (num_layers == '0) begin
                            state_reg <= FINISH;
                        end else begin
                            state_reg <= RD;
                            mem_re    <= 1'b1;
                            mem_addr  <= desc_word_addr(desc_base, 32'd0, WSEL_MAPPING);
                        end
                    end
                end
                RD: begin
                    state_reg     <= WR;
                    ctrl_reg_w_en <= 1'b1;
                    ctrl_reg_wsel <= word_reg;
                end
                WR: begin
                    if (word_reg == WSEL_OPCFG) begin
                        op_cfg_q  <= mem_rdata | START_MASK;
                        state_reg <= WAIT_DONE;
                    end else begin
                        word_reg  <= next_word(word_reg);
                        state_reg <= RD;
                        mem_re    <= 1'b1;
                        mem_addr  <= desc_word_addr(base_reg, 32'(layer_idx), next_word(word_reg));
                    end
                end
                WAIT_DONE: begin
                    // A done arriving on the expiry cycle still counts as a clean finish.
                    if (dla_done || wd_expired) begin
                        err           <= !dla_done;
                        state_reg     <= CLR;
                        ctrl_reg_w_en <= 1'b1;
                        ctrl_reg_wsel <= WSEL_OPCFG;
                    end
                end
                CLR: begin
                    state_reg <= WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (!dla_done) begin
                        if (err || (layer_idx == nlayers_reg - 1'b1)) begin
                            state_reg <= FINISH;
                        end else begin
                            layer_idx <= layer_idx + 1'b1;
                            word_reg  <= WSEL_MAPPING;
                            state_reg <= RD;
                            mem_re    <= 1'b1;
                            mem_addr  <= desc_word_addr(base_reg, 32'(layer_idx) + 32'd1, WSEL_MAPPING);
                        end
                    end
                end
                FINISH: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dla_layer_sequencer.md
Name: dla_layer_sequencer

Overview:
- Upstream command stage for the DLA top level.
- Walks a list of per-layer descriptors in a descriptor memory and programs the DLA control-register write port for each layer: mapping_param, shape_param1, shape_param2, then op_config.
- Waits for dla_done, clears op_config[0] to return the DLA to idle, then moves to the next layer.
- Gives the host a single start/done pair for a multi-layer run, plus a watchdog error flag.

Parameters:
- MAX_LAYERS_BITS, 8, width of num_layers and layer_idx.
- TIMEOUT_BITS, 24, width of the watchdog counter.
- TIMEOUT_CYCLES, 24'hFF_FFFF, maximum cycles spent in WAIT_DONE before err is set.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; begins a run; ignored when busy=1
- desc_base  input  32  byte address of descriptor 0; sampled on accepted start
- num_layers  input  MAX_LAYERS_BITS  layer count; sampled on accepted start
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at end of run (normal or error)
- err  output  1  sticky watchdog error; cleared on next accepted start
- layer_idx  output  MAX_LAYERS_BITS  index of the layer in progress
- mem_re  output  1  descriptor memory read enable
- mem_addr  output  32  descriptor byte address
- mem_rdata  input  32  read data, valid exactly one cycle after mem_re
- ctrl_reg_w_en  output  1  DLA control-register write strobe
- ctrl_reg_wsel  output  2  0=mapping_param, 1=shape_param1, 2=shape_param2, 3=op_config
- ctrl_reg_wdata  output  32  write data
- dla_done  input  1  DLA done level

Behaviour:
- Descriptor layout: 4 words per layer, 16 bytes. Word k is at desc_base + (layer_idx<<4) + (k<<2). k=0..2 map to wsel 0..2; k=3 is op_config.
- Reset values: all outputs 0; state IDLE; internal counters 0.
- IDLE: on start, latch desc_base and num_layers, clear err, set layer_idx=0 and word=0, busy=1.
  - If num_layers==0, go to FINISH with no memory access.
  - Otherwise go to RD.
- RD (1 cycle): mem_re=1 with mem_addr for the current word, then go to WR.
- WR (1 cycle): ctrl_reg_w_en=1, wsel=word, wdata=mem_rdata (combinational pass-through).
  - For word 3, wdata = mem_rdata | 1 so bit0 (start) is always set; the unmodified-plus-bit0 value is latched as op_cfg_q.
  - word<3: word++ and go to RD. word==3: clear the watchdog and go to WAIT_DONE.
- Throughput: exactly 8 cycles from the first RD to the op_config write.
- WAIT_DONE: watchdog increments every cycle.
  - dla_done==1: go to CLR.
  - Watchdog reaches TIMEOUT_CYCLES: set err and go to CLR; the remaining layers are abandoned.
  - dla_done and timeout in the same cycle: done wins, err stays 0.
- CLR (1 cycle): ctrl_reg_w_en=1, wsel=3, wdata = op_cfg_q & ~32'h1. Go to WAIT_IDLE.
- WAIT_IDLE: wait for dla_done==0. Then:
  - err==1, or layer_idx==num_layers-1: go to FINISH.
  - Otherwise: layer_idx++, word=0, go to RD.
- FINISH (1 cycle): done=1, busy=0 from the next cycle, go to IDLE.
- Write ordering guarantee: no wsel 0..2 write is ever issued while dla_done=1. The DLA accepts only op_config writes in its done state.
- ctrl_reg_w_en is asserted only in WR and CLR, never on two consecutive layers' boundary without WAIT_IDLE in between.
- Address arithmetic: 32-bit modulo; wrap-around is not checked.
- Reset mid-run: asynchronous return to IDLE with all outputs 0. The DLA is reset by the same rst.
- start during busy: ignored; no state, parameter, or err change.

Decomposition:
- Shared package dla_seq_pkg:
  - state enum {IDLE, RD, WR, WAIT_DONE, CLR, WAIT_IDLE, FINISH}
  - constants WSEL_MAPPING=0, WSEL_SHAPE1=1, WSEL_SHAPE2=2, WSEL_OPCFG=3, DESC_BYTES=16, OPCFG_START_BIT=0
- Sub-module dla_seq_watchdog: counter with clear, enable, and an expired flag. Everything else stays in one module.

Test Plan:
- Single layer: num_layers=1, desc_base=0x100, words {0x1234,0xA,0xB,0x400}.
  - Writes (wsel,data) = (0,0x1234),(1,0xA),(2,0xB),(3,0x401) at cycles 2,4,6,8 after start.
  - Raise dla_done 10 cycles later → one CLR write (3,0x400).
  - Drop dla_done → done pulse, err=0.
- Three layers at desc_base=0x40: mem_addr sequence 0x40..0x4C, 0x50..0x5C, 0x60..0x6C. layer_idx 0,1,2. Exactly 15 writes. One done pulse.
- num_layers=0: done pulses 2 cycles after start. mem_re and ctrl_reg_w_en never assert.
- Watchdog: TIMEOUT_CYCLES=20, dla_done held 0, num_layers=3.
  - err=1 after 20 WAIT_DONE cycles, then the CLR write and done. Layers 1 and 2 are never fetched.
  - The next start clears err.
- start pulsed again in WAIT_DONE with a different desc_base → ignored. Addresses for the next layer follow the original base.
- rst asserted during WR → all outputs 0 immediately (asynchronous). After release, busy=0 until a new start.
